mem_rr_arbiter: RTL and testbench



---
 rtl/mem_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter sharing one data-memory port among
// NUM_CH requesters. The winning channel's command is latched so the memory
// sees stable inputs for the whole transaction; responses are steered back
// combinationally to the granted channel only, and a stuck transaction is
// aborted with a one-cycle error pulse after TIMEOUT busy cycles.
module mem_rr_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 64,
  parameter int XLEN    = 64,
  parameter int WLEN_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  // Requester side
  input  logic [NUM_CH*ADDR_W-1:0]   data_addr_in,
  input  logic [NUM_CH-1:0]          rdata_en_in,
  input  logic [NUM_CH-1:0]          wdata_en_in,
  input  logic [NUM_CH*XLEN-1:0]     wdata_in,
  input  logic [NUM_CH*WLEN_W-1:0]   wlen_in,
  output logic [NUM_CH-1:0]          wdata_ready_out,
  output logic [XLEN-1:0]            rdata_out,
  output logic [NUM_CH-1:0]          rdata_valid_out,
  output logic [NUM_CH-1:0]          err_out,
  // Memory side
  output logic [ADDR_W-1:0]          data_addr_out,
  output logic                       rdata_en_out,
  output logic                       wdata_en_out,
  output logic [XLEN-1:0]            wdata_out,
  output logic [WLEN_W-1:0]          wlen_out,
  input  logic                       wdata_ready_in,
  input  logic [XLEN-1:0]            rdata_in,
  input  logic                       rdata_valid_in
);

  localparam int CH_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int TCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit TMO_EN = (TIMEOUT != 0);
  // Value of the busy-cycle counter in the last cycle before an abort.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e              state_q;
  logic [CH_W-1:0]     grant_q;
  logic [CH_W-1:0]     ptr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [WLEN_W-1:0]   wlen_q;
  logic                is_write_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic [TCNT_W-1:0]   tcnt_q;

  logic [NUM_CH-1:0]   req;
  logic                any_req;
  logic [CH_W-1:0]     grant_d;
  logic [CH_W-1:0]     ptr_d;
  int                  idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [XLEN-1:0]     sel_wdata;
  logic [WLEN_W-1:0]   sel_wlen;
  logic                sel_write;

  logic                busy;
  logic                done;
  logic                tmo;
  logic [NUM_CH-1:0]   grant_oh;

  // Round-robin pick: first requester at or after ptr_q, wrapping around.
  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    req     = rdata_en_in | wdata_en_in;
    any_req = |req;
    grant_d = '0;
    idx     = 0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) grant_d = CH_W'(idx);
    end
    sel_addr  = data_addr_in[int'(grant_d)*ADDR_W +: ADDR_W];
    sel_wdata = wdata_in[int'(grant_d)*XLEN +: XLEN];
    sel_wlen  = wlen_in[int'(grant_d)*WLEN_W +: WLEN_W];
    sel_write = wdata_en_in[grant_d];
  end

  // Pointer after a transaction ends: the channel following the granted one.
  assign ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);

  assign busy     = (state_q == BUSY);
  assign done     = busy & (is_write_q ? wdata_ready_in : rdata_valid_in);
  // A completion arriving in the final allowed cycle wins over the abort.
  assign tmo      = TMO_EN & busy & ~done & (tcnt_q == TCNT_LAST);
  assign grant_oh = NUM_CH'(1) << grant_q;

  // Responses reach only the granted channel, with no added latency.
  assign wdata_ready_out = (done &  is_write_q) ? grant_oh : '0;
  assign rdata_valid_out = (done & ~is_write_q) ? grant_oh : '0;
  assign err_out         = tmo ? grant_oh : '0;
  assign rdata_out       = rdata_in;

  // Memory side is driven purely from registers.
  assign data_addr_out = addr_q;
  assign wdata_out     = wdata_q;
  assign wlen_out      = wlen_q;
  assign rdata_en_out  = rd_en_q;
  assign wdata_en_out  = wr_en_q;

  // Arbitration FSM: grant and latch in IDLE, wait for completion or timeout in BUSY.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the command latch is reset too, because the memory-side
      // outputs it drives must read zero straight after reset.
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wlen_q     <= '0;
      is_write_q <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= grant_d;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            wlen_q     <= sel_wlen;
            // A write request takes precedence over a simultaneous read.
            is_write_q <= sel_write;
            wr_en_q    <= sel_write;
            rd_en_q    <= ~sel_write;
            tcnt_q     <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (done || tmo) begin
            ptr_q   <= ptr_d;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter. A transaction-level reference model
// (next-preferred pointer plus a per-grant command snapshot) predicts the
// granted channel, the latched memory command and the response steering.
// A second instance with TIMEOUT=4 covers the abort path.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int XW = 64;
  localparam int LW = 4;

  logic clk;
  logic rst;

  logic [AW-1:0] addr_a  [N];
  logic [XW-1:0] wdata_a [N];
  logic [LW-1:0] wlen_a  [N];
  logic [N-1:0]  rd_en, wr_en;
  logic [N-1:0]  rereq;

  logic [N*AW-1:0] data_addr_in;
  logic [N*XW-1:0] wdata_in;
  logic [N*LW-1:0] wlen_in;

  logic          wready_in, rvalid_in;
  logic [XW-1:0] rdata_in;

  // Main instance outputs
  logic [N-1:0]  wready_out, rvalid_out, err_out;
  logic [XW-1:0] rdata_out, wdata_out;
  logic [AW-1:0] addr_out;
  logic          rd_en_out, wr_en_out;
  logic [LW-1:0] wlen_out;

  // Timeout instance outputs
  logic [N-1:0]  to_wready, to_rvalid, to_err;
  logic [XW-1:0] to_rdata, to_wdata;
  logic [AW-1:0] to_addr;
  logic          to_rd_en, to_wr_en;
  logic [LW-1:0] to_wlen;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_ptr;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_addr_in[i*AW +: AW] = addr_a[i];
      wdata_in[i*XW +: XW]     = wdata_a[i];
      wlen_in[i*LW +: LW]      = wlen_a[i];
    end
  end

  mem_rr_arbiter #(.NUM_CH(N), .ADDR_W(AW), .XLEN(XW), .WLEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .data_addr_in(data_addr_in), .rdata_en_in(rd_en), .wdata_en_in(wr_en),
    .wdata_in(wdata_in), .wlen_in(wlen_in),
    .wdata_ready_out(wready_out), .rdata_out(rdata_out),
    .rdata_valid_out(rvalid_out), .err_out(err_out),
    .data_addr_out(addr_out), .rdata_en_out(rd_en_out), .wdata_en_out(wr_en_out),
    .wdata_out(wdata_out), .wlen_out(wlen_out),
    .wdata_ready_in(wready_in), .rdata_in(rdata_in), .rdata_valid_in(rvalid_in)
  );

  mem_rr_arbiter #(.NUM_CH(N), .ADDR_W(AW), .XLEN(XW), .WLEN_W(LW), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst),
    .data_addr_in(data_addr_in), .rdata_en_in(rd_en), .wdata_en_in(wr_en),
    .wdata_in(wdata_in), .wlen_in(wlen_in),
    .wdata_ready_out(to_wready), .rdata_out(to_rdata),
    .rdata_valid_out(to_rvalid), .err_out(to_err),
    .data_addr_out(to_addr), .rdata_en_out(to_rd_en), .wdata_en_out(to_wr_en),
    .wdata_out(to_wdata), .wlen_out(to_wlen),
    .wdata_ready_in(wready_in), .rdata_in(rdata_in), .rdata_valid_in(rvalid_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_en = '0; wr_en = '0; rereq = '0;
    wready_in = 1'b0; rvalid_in = 1'b0; rdata_in = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0; wdata_a[i] = '0; wlen_a[i] = '0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // New random command fields on every channel; the latch must ignore them.
  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = {$urandom, $urandom};
      wdata_a[i] = {$urandom, $urandom};
      wlen_a[i]  = LW'($urandom);
    end
  endtask

  // Reference arbitration: first requester found walking from the pointer.
  function automatic int ref_pick(input int ptr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One transaction on the main instance, starting in an IDLE cycle with the
  // caller's requests already set. lat = stall cycles before completion;
  // wrong = drive the opposite kind of response during the stall.
  task automatic do_txn(input int lat, input bit wrong, output int g);
    logic [AW-1:0] ea;
    logic [XW-1:0] ew;
    logic [LW-1:0] el;
    logic [N-1:0]  oh;
    bit            w;
    #1;
    chk("idle_rd_en", rd_en_out, 0);
    chk("idle_wr_en", wr_en_out, 0);
    g  = ref_pick(model_ptr, rd_en | wr_en);
    ea = addr_a[g]; ew = wdata_a[g]; el = wlen_a[g]; w = wr_en[g];
    oh = N'(1) << g;
    tick();
    rd_en = rd_en | rereq;
    rereq = '0;
    for (int c = 0; c < lat; c++) begin
      scramble();
      rdata_in = {$urandom, $urandom};
      if (wrong) begin
        if (w) rvalid_in = 1'b1; else wready_in = 1'b1;
      end
      #1;
      chk("busy_rd_en", rd_en_out, !w);
      chk("busy_wr_en", wr_en_out, w);
      chk("busy_addr",  addr_out, ea);
      chk("busy_wdata", wdata_out, ew);
      chk("busy_wlen",  wlen_out, el);
      chk("stall_rvalid", rvalid_out, 0);
      chk("stall_wready", wready_out, 0);
      chk("stall_err",  err_out, 0);
      chk("rdata_pass", rdata_out, rdata_in);
      tick();
      rvalid_in = 1'b0; wready_in = 1'b0;
    end
    scramble();
    rdata_in = {$urandom, $urandom};
    if (w) wready_in = 1'b1; else rvalid_in = 1'b1;
    #1;
    chk("done_addr",   addr_out, ea);
    chk("done_wdata",  wdata_out, ew);
    chk("done_wlen",   wlen_out, el);
    chk("done_wready", wready_out, w ? oh : '0);
    chk("done_rvalid", rvalid_out, w ? '0 : oh);
    chk("done_err",    err_out, 0);
    chk("done_rdata",  rdata_out, rdata_in);
    tick();
    rvalid_in = 1'b0; wready_in = 1'b0;
    rd_en[g] = 1'b0; wr_en[g] = 1'b0;
    model_ptr = (g + 1) % N;
  endtask

  initial begin
    int g;
    logic [N-1:0] fresh;

    // Reset state: everything zero while reset is held.
    apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_rd_en",  rd_en_out, 0);
    chk("rst_wr_en",  wr_en_out, 0);
    chk("rst_addr",   addr_out, 0);
    chk("rst_wdata",  wdata_out, 0);
    chk("rst_wlen",   wlen_out, 0);
    chk("rst_rvalid", rvalid_out, 0);
    chk("rst_wready", wready_out, 0);
    chk("rst_err",    err_out, 0);
    chk("rst_rdata",  rdata_out, 0);
    rst = 1'b0;

    // ch2 reads 0x100, memory answers 0xDEAD one cycle after enable.
    addr_a[2] = 64'h100;
    rd_en[2]  = 1'b1;
    #1;
    chk("t1_en_c0", rd_en_out, 0);
    tick();
    chk("t1_en_c1", rd_en_out, 1);
    chk("t1_addr",  addr_out, 64'h100);
    rvalid_in = 1'b1; rdata_in = 64'hDEAD;
    #1;
    chk("t1_rvalid", rvalid_out, 4'b0100);
    chk("t1_rdata",  rdata_out, 64'hDEAD);
    tick();
    rvalid_in = 1'b0; rd_en[2] = 1'b0;
    #1;
    chk("t1_en_after", rd_en_out, 0);
    chk("t1_ptr", dut.ptr_q, 3);
    model_ptr = 3;

    // All four channels request continuously with 1-cycle memory.
    apply_reset();
    scramble();
    rd_en = 4'hF;
    for (int i = 0; i < 5; i++) begin
      do_txn(0, 1'b0, g);
      rereq[g] = 1'b1;
    end
    rd_en = '0; rereq = '0;
    tick();

    // ch1 write 0xCAFE wlen 8, memory stalls 5 cycles while inputs change.
    wdata_a[1] = 64'hCAFE; wlen_a[1] = 4'd8; addr_a[1] = 64'h2000;
    wr_en[1] = 1'b1;
    do_txn(5, 1'b0, g);

    // ch0 asserts both enables; stray read-valid pulses must be ignored.
    addr_a[0] = 64'h3000;
    rd_en[0] = 1'b1; wr_en[0] = 1'b1;
    do_txn(3, 1'b1, g);

    // Randomised traffic against the model.
    for (int t = 0; t < 40; t++) begin
      fresh = N'($urandom) & ~(rd_en | wr_en);
      for (int i = 0; i < N; i++) begin
        if (fresh[i]) begin
          addr_a[i]  = {$urandom, $urandom};
          wdata_a[i] = {$urandom, $urandom};
          wlen_a[i]  = LW'($urandom);
          if ($urandom_range(0, 1) == 1) wr_en[i] = 1'b1;
          if ($urandom_range(0, 1) == 1 || !wr_en[i]) rd_en[i] = 1'b1;
        end
      end
      if ((rd_en | wr_en) == '0) rd_en[$urandom_range(0, N - 1)] = 1'b1;
      do_txn($urandom_range(0, 4), 1'(($urandom % 2)), g);
    end
    rd_en = '0; wr_en = '0;
    tick();

    // Reset during BUSY: a late write-ready must not be forwarded.
    wr_en[1] = 1'b1; addr_a[1] = 64'h4000;
    tick();
    chk("rb_busy_wr_en", wr_en_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = '0;
    wready_in = 1'b1;
    #1;
    chk("rb_wr_en",  wr_en_out, 0);
    chk("rb_rd_en",  rd_en_out, 0);
    chk("rb_wready", wready_out, 0);
    chk("rb_err",    err_out, 0);
    chk("rb_addr",   addr_out, 0);
    chk("rb_ptr",    dut.ptr_q, 0);
    wready_in = 1'b0;
    model_ptr = 0;

    // TIMEOUT=4 instance: ch3 read, memory silent.
    apply_reset();
    rd_en[3] = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk("to_en_wait",  to_rd_en, 1);
      chk("to_err_wait", to_err, 0);
      tick();
    end
    #1;
    chk("to_err_pulse", to_err, 4'b1000);
    chk("to_en_at_err", to_rd_en, 1);
    chk("to_rvalid_at_err", to_rvalid, 0);
    tick();
    rd_en[3] = 1'b0;
    #1;
    chk("to_en_after", to_rd_en, 0);
    chk("to_err_after", to_err, 0);
    chk("to_ptr", dut_to.ptr_q, 0);

    // Completion landing on the 4th busy cycle beats the abort.
    rd_en[3] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rvalid_in = 1'b1; rdata_in = 64'h55;
    #1;
    chk("to_late_rvalid", to_rvalid, 4'b1000);
    chk("to_late_err", to_err, 0);
    tick();
    rvalid_in = 1'b0; rd_en = '0;
    #1;
    chk("to_late_en_after", to_rd_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
